// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enigma_pkg
// Brief    : Shared types and constants for the Enigma character I/O blocks.
// Revision : 1.0 - initial release
// ============================================================================
package enigma_pkg;

    // UART transmit framing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int         NUM_LETTERS = 26;

    // Letter code 0..25 becomes 'A'..'Z'; anything beyond the alphabet becomes '?'
    function automatic logic [7:0] code_to_ascii(input logic [4:0] code);
        if (int'(code) < NUM_LETTERS) begin
            return ASCII_A + {3'b000, code};
        end
        return ASCII_QMARK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_char_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with first-word fall-through read port.
//            A push into a full FIFO is accepted when a pop happens in the
//            same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == (c_AW+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage array needs no reset; only valid entries are ever read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (c_AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - (c_AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/enigma_char_tx.sv
`default_nettype none
// ============================================================================
// Module   : enigma_char_tx
// Brief    : Captures Enigma cipher codes, converts them to ASCII, buffers
//            them and streams them out as 8N1 UART frames.
//            Optional macro ENIGMA_TX_GROUP5_EN inserts a space frame after
//            every fifth character frame.
// Revision : 1.0 - initial release
// ============================================================================
module enigma_char_tx
    import enigma_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [4:0]                    char_in,
    input  logic                          char_valid,
    input  logic                          overflow_clr,
    output logic                          uart_txd,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_BIT_CYCLES = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int c_CNT_W      = (c_BIT_CYCLES > 1) ? $clog2(c_BIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_RELOAD = c_CNT_W'(c_BIT_CYCLES - 1);

    tx_state_t               r_state, w_state_nx;
    logic [c_CNT_W-1:0]      r_baud_cnt, w_baud_nx;
    logic [2:0]              r_bit_cnt, w_bit_nx;
    logic [7:0]              r_shift, w_shift_nx;
    logic                    r_txd, w_txd_nx;
    logic                    r_ovf;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [7:0]              w_fifo_dout;
    logic                    w_bit_end;
    logic                    w_frame_done;
    logic                    w_drop;
    logic                    w_space_go;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (char_valid),
        .pop     (w_pop),
        .din     (code_to_ascii(char_in)),
        .dout    (w_fifo_dout),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    assign w_bit_end    = (r_baud_cnt == '0);
    assign w_frame_done = (r_state == STOP) && w_bit_end;
    assign w_drop       = char_valid & w_full & ~w_pop;

`ifdef ENIGMA_TX_GROUP5_EN
    logic [2:0] r_grp;
    logic       r_space_pend;
    logic       r_is_space;

    assign w_space_go = r_space_pend;

    // Count finished letter frames and queue a space after each fifth one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grp        <= '0;
            r_space_pend <= 1'b0;
            r_is_space   <= 1'b0;
        end else begin
            if (w_frame_done && !r_is_space) begin
                if (r_grp == 3'd4) begin
                    r_grp        <= '0;
                    r_space_pend <= 1'b1;
                end else begin
                    r_grp <= r_grp + 3'd1;
                end
            end
            if (r_state == IDLE && r_space_pend) begin
                r_space_pend <= 1'b0;
                r_is_space   <= 1'b1;
            end else if (w_pop) begin
                r_is_space <= 1'b0;
            end
        end
    end
`else
    assign w_space_go = 1'b0;
`endif

    // Frame sequencing; the line level is computed one cycle early so the pin is a flop
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud_cnt;
        w_bit_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        w_txd_nx   = 1'b1;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nx = '0;
                w_bit_nx  = '0;
                if (w_space_go) begin
                    w_state_nx = START;
                    w_shift_nx = ASCII_SPACE;
                    w_baud_nx  = c_BAUD_RELOAD;
                    w_txd_nx   = 1'b0;
                end else if (!w_empty) begin
                    w_state_nx = START;
                    w_pop      = 1'b1;
                    w_shift_nx = w_fifo_dout;
                    w_baud_nx  = c_BAUD_RELOAD;
                    w_txd_nx   = 1'b0;
                end
            end
            START: begin
                w_txd_nx = 1'b0;
                if (w_bit_end) begin
                    w_state_nx = DATA;
                    w_bit_nx   = '0;
                    w_baud_nx  = c_BAUD_RELOAD;
                    w_txd_nx   = r_shift[0];
                end else begin
                    w_baud_nx = r_baud_cnt - c_CNT_W'(1);
                end
            end
            DATA: begin
                w_txd_nx = r_shift[0];
                if (w_bit_end) begin
                    w_baud_nx = c_BAUD_RELOAD;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nx = STOP;
                        w_txd_nx   = 1'b1;
                    end else begin
                        w_bit_nx   = r_bit_cnt + 3'd1;
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_txd_nx   = r_shift[1];
                    end
                end else begin
                    w_baud_nx = r_baud_cnt - c_CNT_W'(1);
                end
            end
            STOP: begin
                w_txd_nx = 1'b1;
                if (w_bit_end) begin
                    w_state_nx = IDLE;
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                end else begin
                    w_baud_nx = r_baud_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // FSM and line register; reset forces the line high without waiting for a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_nx;
            r_bit_cnt  <= w_bit_nx;
            r_shift    <= w_shift_nx;
            r_txd      <= w_txd_nx;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (overflow_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign uart_txd = r_txd;
    assign overflow = r_ovf;
    assign busy     = (r_state != IDLE) | (fifo_level != '0) | w_space_go;

endmodule
`default_nettype wire

// File: tb/tb_enigma_char_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_enigma_char_tx
// Brief    : Self-checking bench for enigma_char_tx with a line decoder and
//            a byte-stream reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enigma_char_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int BC     = 10;
    localparam int DEPTH  = 16;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic [4:0] char_in      = '0;
    logic       char_valid   = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       uart_txd;
    logic       busy;
    logic       overflow;
    logic [4:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_byte[$];
    int         rx_start[$];
    bit         rx_ok[$];

    enigma_char_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .char_in      (char_in),
        .char_valid   (char_valid),
        .overflow_clr (overflow_clr),
        .uart_txd     (uart_txd),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples mid-bit and records every frame it sees
    initial begin : line_monitor
        int         st;
        bit         ok;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && uart_txd === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                repeat (BC / 2) @(negedge clk);
                if (uart_txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BC) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (BC) @(negedge clk);
                if (uart_txd !== 1'b1) ok = 1'b0;
                rx_byte.push_back(b);
                rx_start.push_back(st);
                rx_ok.push_back(ok);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_ascii(input int code);
        if (code < 26) return 8'(65 + code);
        return 8'h3F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_one(input int code);
        char_in    = 5'(code);
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic clear_q();
        exp_q.delete();
        rx_byte.delete();
        rx_start.delete();
        rx_ok.delete();
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (uart_txd !== 1'b0 && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
        tick(3);
    endtask

    task automatic compare_rx(input string tag);
        check($sformatf("%s_count", tag), rx_byte.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_byte.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_byte[i], exp_q[i]);
            check($sformatf("%s_frame%0d", tag, i), 32'(rx_ok[i]), 32'd1);
        end
    endtask

    initial begin : stimulus
        int         c;
        int         s;
        int         peak;
        int         n;
        logic [7:0] b;

        // Reset values and quiet idle line
        tick(3);
        check("reset_vals", {uart_txd, busy, overflow, fifo_level}, {1'b1, 1'b0, 1'b0, 5'd0});
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            check("idle_hold", {uart_txd, busy, fifo_level}, {1'b1, 1'b0, 5'd0});
        end

`ifdef ENIGMA_TX_GROUP5_EN
        // Five-letter grouping: codes 0..6 give "ABCDE FG"
        clear_q();
        peak = 0;
        for (int i = 0; i < 7; i++) begin
            char_in    = 5'(i);
            char_valid = 1'b1;
            @(negedge clk);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        char_valid = 1'b0;
        for (int i = 0; i < 900; i++) begin
            tick(1);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (busy === 1'b0) break;
        end
        wait_idle("group_idle", 100);
        check("group_peak", peak, 6);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46, 8'h47};
        compare_rx("group");
`else
        // Single letter: exact start latency and bit-level waveform
        clear_q();
        b = to_ascii(0);
        push_one(0);
        check("single_level1", fifo_level, 5'd1);
        check("single_pre_start", uart_txd, 1'b1);
        tick(1);
        check("single_start_edge", uart_txd, 1'b0);
        check("single_busy", busy, 1'b1);
        check("single_popped", fifo_level, 5'd0);
        tick(BC / 2);
        check("single_startbit", uart_txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(BC);
            check($sformatf("single_bit%0d", i), uart_txd, b[i]);
        end
        tick(BC);
        check("single_stopbit", uart_txd, 1'b1);
        tick(4);
        check("single_busy_last", busy, 1'b1);
        tick(1);
        check("single_busy_drop", busy, 1'b0);
        tick(5);

        // Back-to-back frames: 'Z' then '?'
        clear_q();
        char_in    = 5'd25;
        char_valid = 1'b1;
        @(negedge clk);
        char_in = 5'd30;
        @(negedge clk);
        char_valid = 1'b0;
        exp_q.push_back(to_ascii(25));
        exp_q.push_back(to_ascii(30));
        wait_idle("b2b_idle", 400);
        compare_rx("b2b");
        if (rx_start.size() >= 2) check("b2b_period", rx_start[1] - rx_start[0], 10 * BC + 1);

        // 17 consecutive random pushes while idle: none dropped, peak 16
        clear_q();
        peak = 0;
        for (int i = 0; i < 17; i++) begin
            c          = int'($urandom_range(0, 31));
            char_in    = 5'(c);
            char_valid = 1'b1;
            exp_q.push_back(to_ascii(c));
            @(negedge clk);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        char_valid = 1'b0;
        check("burst_peak", peak, DEPTH);
        check("burst_no_ovf", overflow, 1'b0);
        wait_idle("burst_idle", 17 * 101 + 50);
        compare_rx("burst");

        // Stalled line: overflow, clear, set-dominance, full push+pop
        clear_q();
        c = int'($urandom_range(0, 31));
        push_one(c);
        exp_q.push_back(to_ascii(c));
        wait_fall("stall_fall");
        s = cyc;
        for (int i = 0; i < 17; i++) begin
            c          = int'($urandom_range(0, 31));
            char_in    = 5'(c);
            char_valid = 1'b1;
            if (i < 16) exp_q.push_back(to_ascii(c));
            @(negedge clk);
        end
        char_valid = 1'b0;
        check("stall_ovf_set", overflow, 1'b1);
        check("stall_level", fifo_level, 5'd16);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("stall_ovf_clr", overflow, 1'b0);
        overflow_clr = 1'b1;
        char_valid   = 1'b1;
        char_in      = 5'(int'($urandom_range(0, 31)));
        @(negedge clk);
        overflow_clr = 1'b0;
        char_valid   = 1'b0;
        check("stall_ovf_dominant", overflow, 1'b1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("stall_ovf_clr2", overflow, 1'b0);
        while (cyc < s + 10 * BC) tick(1);
        c          = int'($urandom_range(0, 31));
        char_in    = 5'(c);
        char_valid = 1'b1;
        exp_q.push_back(to_ascii(c));
        @(negedge clk);
        char_valid = 1'b0;
        check("full_pushpop_level", fifo_level, 5'd16);
        check("full_pushpop_ovf", overflow, 1'b0);
        wait_idle("stall_idle", 19 * 101 + 50);
        compare_rx("stall");

        // Random gaps, never enough to overflow
        for (int r = 0; r < 3; r++) begin
            clear_q();
            n = int'($urandom_range(3, 10));
            for (int i = 0; i < n; i++) begin
                c = int'($urandom_range(0, 31));
                push_one(c);
                exp_q.push_back(to_ascii(c));
                tick(int'($urandom_range(0, 40)));
            end
            wait_idle($sformatf("rand%0d_idle", r), 12 * 101);
            compare_rx($sformatf("rand%0d", r));
        end

        // Reset in the middle of a data bit
        clear_q();
        push_one(int'($urandom_range(0, 31)));
        wait_fall("rst_fall");
        s = cyc;
        for (int i = 0; i < 18; i++) begin
            char_in    = 5'(int'($urandom_range(0, 31)));
            char_valid = 1'b1;
            @(negedge clk);
        end
        char_valid = 1'b0;
        check("rst_pre_ovf", overflow, 1'b1);
        while (cyc < s + 4 * BC + 3) tick(1);
        reset_n = 1'b0;
        #1;
        check("rst_async", {uart_txd, busy, overflow, fifo_level}, {1'b1, 1'b0, 1'b0, 5'd0});
        tick(2);
        reset_n = 1'b1;
        tick(120);
        clear_q();
        c = int'($urandom_range(0, 31));
        push_one(c);
        exp_q.push_back(to_ascii(c));
        wait_idle("rst_idle", 300);
        compare_rx("post_rst");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enigma_char_tx.md
# enigma_char_tx

Output stage directly downstream of the Enigma core. It captures each encrypted character code (0–25) when the core presents it, converts it to upper-case ASCII, and buffers it in a small FIFO. It then serialises the buffered characters onto the board UART TX line as 8N1 frames, so ciphertext streams to the host without software polling the output register.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; BIT_CYCLES = (CLK_HZ + BAUD/2) / BAUD, rounded to nearest
- FIFO_DEPTH, 16, character FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- char_in  in  5  encrypted character code from the Enigma core
- char_valid  in  1  single-cycle strobe; char_in is valid this cycle
- overflow_clr  in  1  clears the sticky overflow flag
- uart_txd  out  1  serial output; idles high
- busy  out  1  high while a frame is on the line or the FIFO is non-empty
- overflow  out  1  sticky; set when a char_valid is dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Code conversion happens at push. Codes 0–25 map to 0x41 + code ('A'–'Z'). Codes 26–31 map to 0x3F ('?').
- Push: char_valid with FIFO not full writes the ASCII byte. char_valid with FIFO full drops the byte and sets overflow.
- If push and pop occur in the same cycle with FIFO full, the push is accepted and the level is unchanged.
- overflow: set-dominant over overflow_clr in the same cycle. Otherwise it clears on overflow_clr.
- TX FSM states and transitions:
  - IDLE → START when the FIFO is non-empty; the head byte is popped into the shift register in this same cycle.
  - START: drives 0 for BIT_CYCLES.
  - DATA: drives 8 bits, LSB first, BIT_CYCLES each.
  - STOP: drives 1 for BIT_CYCLES, then returns to IDLE.
- The bit counter runs 0–7 in DATA. The baud counter counts down from BIT_CYCLES−1 and reloads at each bit boundary.
- uart_txd is a registered output: no combinational path from FSM to pin.
- busy = (state != IDLE) | (fifo_level != 0).
- Reset mid-frame: FSM goes to IDLE, FIFO empties, uart_txd goes high immediately (asynchronously), and overflow clears. The partial frame is abandoned; the host sees a framing error, which is acceptable.

## Timing
- Reset values: uart_txd=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, all counters 0.
- A push is visible on fifo_level the cycle after char_valid.
- With an empty FIFO and FSM in IDLE:
  - uart_txd falls 2 cycles after the char_valid cycle (1 cycle FIFO write, 1 cycle IDLE→START registered).
- Frame length: exactly 10×BIT_CYCLES cycles.
- Back-to-back frames: the next start bit follows the stop bit with 1 IDLE cycle, so the frame period is 10×BIT_CYCLES+1.
- char_valid is accepted every cycle. There is no backpressure to the core; loss is reported only through overflow.

## Configuration
- ENIGMA_TX_GROUP5_EN defined: after every 5th character frame, the FSM inserts a space frame (0x20) before the next FIFO pop. This gives classic 5-letter grouping.
  - The group counter counts transmitted characters 0–4, wraps, and clears on reset.
  - The space does not occupy a FIFO entry and does not change fifo_level.
  - busy stays high through a pending space.
- Undefined: no insertion; the group counter logic is absent.

## Structure
- Shared package enigma_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP)
  - ASCII_A = 8'h41, ASCII_QMARK = 8'h3F, ASCII_SPACE = 8'h20
  - the NUM_LETTERS = 26 constant
- One sub-module: sync_fifo (parameterised width/depth; push/pop/full/empty/level). It is reusable for the RX side.
- The FSM, baud counter, and code conversion live in enigma_char_tx itself.

## Test plan
Use CLK_HZ=1_000_000, BAUD=100_000 (BIT_CYCLES=10).
- Reset then idle: uart_txd=1, busy=0, fifo_level=0 held for 100 cycles.
- Single char_in=0: uart_txd falls at cycle +2, then serialises 0x41 LSB first (1,0,0,0,0,0,1,0), stop=1. busy drops at the end of the stop bit.
- char_in=25, then char_in=30: bytes 0x5A and 0x3F are sent back-to-back, with the second start bit exactly 101 cycles after the first.
- Push 17 chars in 17 consecutive cycles with FIFO_DEPTH=16 while idle:
  - The first is popped at cycle +1, so none are dropped, and fifo_level peaks at 16.
  - Repeating the test with a stalled line drops one byte, overflow=1. overflow_clr clears it, and a simultaneous drop keeps it set.
- Assert reset_n low mid-DATA: uart_txd=1 and fifo_level=0 immediately. After release, a new char is transmitted cleanly.
- With ENIGMA_TX_GROUP5_EN: push codes 0–6 and observe "ABCDE FG" on the line, with fifo_level never counting the space.
